// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: width defaults, FSM encodings and the grant enum.
package vram_pkg;

  localparam int unsigned AW_DEF = 17;
  localparam int unsigned FW_DEF = 12;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_WAIT = 2'd1,
    C_ACK  = 2'd2
  } cpu_state_e;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_RUN  = 1'b1
  } fill_state_e;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_VID  = 2'd1,
    G_CPU  = 2'd2,
    G_FILL = 2'd3
  } grant_e;

endpackage

// File: rtl/vram_fill.sv
// Block-fill engine: walks an address range writing a constant byte, one write per granted cycle.
// Instantiated by vram_arbiter only when VRAM_FILL_EN is defined.
module vram_fill
  import vram_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned FW = FW_DEF
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          grant_i,
  input  logic [AW-1:0] base_i,
  input  logic [FW-1:0] count_i,
  input  logic [7:0]    value_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] address_o,
  output logic [7:0]    wdata_o
);

  fill_state_e   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic [7:0]    val_q, val_d;
  logic          done_q, done_d;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= F_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      done_q  <= done_d;
    end
  end

  // Address wraps naturally at 2^AW; done is raised on the edge of the last write.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    done_d  = 1'b0;
    case (state_q)
      F_IDLE: begin
        if (start_i) begin
          addr_d = base_i;
          cnt_d  = count_i;
          val_d  = value_i;
          if (count_i == FW'(0)) done_d = 1'b1;
          else                   state_d = F_RUN;
        end
      end
      F_RUN: begin
        if (grant_i) begin
          addr_d = addr_q + AW'(1);
          cnt_d  = cnt_q - FW'(1);
          if (cnt_q == FW'(1)) begin
            state_d = F_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = F_IDLE;
    endcase
  end

  assign busy_o    = (state_q == F_RUN);
  assign done_o    = done_q;
  assign address_o = addr_q;
  assign wdata_o   = val_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: fixed priority video > CPU > fill, CPU handshake FSM.
// Fill engine compiled in only when VRAM_FILL_EN is defined.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned FW = FW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_address,
  output logic          vid_valid,
  output logic [7:0]    vid_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_address,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ack,
  output logic [7:0]    cpu_rdata,
  input  logic          fill_start,
  input  logic [AW-1:0] fill_base,
  input  logic [FW-1:0] fill_count,
  input  logic [7:0]    fill_value,
  output logic          fill_busy,
  output logic          fill_done,
  output logic [AW-1:0] mem_address,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  cpu_state_e    cpu_q, cpu_d;
  grant_e        grant;
  logic          cpu_pending;
  logic          vid_valid_q;
  logic          fill_req;
  logic          fill_gnt;
  logic [AW-1:0] fill_addr;
  logic [7:0]    fill_wdata;

  assign fill_gnt = (grant == G_FILL);

`ifdef VRAM_FILL_EN
  vram_fill #(
    .AW (AW),
    .FW (FW)
  ) u_fill (
    .clock_i   (clock),
    .reset_i   (reset),
    .start_i   (fill_start),
    .grant_i   (fill_gnt),
    .base_i    (fill_base),
    .count_i   (fill_count),
    .value_i   (fill_value),
    .busy_o    (fill_busy),
    .done_o    (fill_done),
    .address_o (fill_addr),
    .wdata_o   (fill_wdata)
  );
  assign fill_req = fill_busy;
`else
  logic unused_fill;
  assign unused_fill = ^{fill_start, fill_base, fill_count, fill_value, fill_gnt};
  assign fill_req    = 1'b0;
  assign fill_addr   = '0;
  assign fill_wdata  = '0;
  assign fill_busy   = 1'b0;
  assign fill_done   = 1'b0;
`endif

  // A CPU access is pending on a fresh request in C_IDLE or while parked in C_WAIT.
  assign cpu_pending = (cpu_q == C_WAIT) || ((cpu_q == C_IDLE) && cpu_req);

  always_comb begin
    grant = G_NONE;
    if (!reset) begin
      if (vid_req)          grant = G_VID;
      else if (cpu_pending) grant = G_CPU;
      else if (fill_req)    grant = G_FILL;
    end
  end

  always_comb begin
    mem_address = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    case (grant)
      G_VID:  mem_address = vid_address;
      G_CPU: begin
        mem_address = cpu_address;
        mem_we      = cpu_we;
        mem_wdata   = cpu_wdata;
      end
      G_FILL: begin
        mem_address = fill_addr;
        mem_we      = 1'b1;
        mem_wdata   = fill_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_q       <= C_IDLE;
      vid_valid_q <= 1'b0;
    end else begin
      cpu_q       <= cpu_d;
      vid_valid_q <= (grant == G_VID);
    end
  end

  // cpu_req is not looked at in C_ACK, so a request held through the ack is serviced once.
  always_comb begin
    cpu_d = cpu_q;
    case (cpu_q)
      C_IDLE: if (cpu_req) cpu_d = (grant == G_CPU) ? C_ACK : C_WAIT;
      C_WAIT: if (!vid_req) cpu_d = C_ACK;
      C_ACK:  cpu_d = C_IDLE;
      default: cpu_d = C_IDLE;
    endcase
  end

  assign cpu_ack   = (cpu_q == C_ACK);
  assign cpu_rdata = cpu_ack ? mem_rdata : 8'h00;
  assign vid_valid = vid_valid_q;
  assign vid_data  = mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: vector table for video/CPU traffic plus fill sequences.
module tb_vram_arbiter;

  localparam int unsigned AW = 17;
  localparam int unsigned FW = 12;

  logic          clock = 1'b0;
  logic          reset;
  logic          vid_req;
  logic [AW-1:0] vid_address;
  logic          vid_valid;
  logic [7:0]    vid_data;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_address;
  logic [7:0]    cpu_wdata;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic          fill_start;
  logic [AW-1:0] fill_base;
  logic [FW-1:0] fill_count;
  logic [7:0]    fill_value;
  logic          fill_busy;
  logic          fill_done;
  logic [AW-1:0] mem_address;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  logic [7:0] vram [0:(1<<AW)-1];

  int checks = 0;
  int failures = 0;

  vram_arbiter #(.AW(AW), .FW(FW)) dut (
    .clock       (clock),
    .reset       (reset),
    .vid_req     (vid_req),
    .vid_address (vid_address),
    .vid_valid   (vid_valid),
    .vid_data    (vid_data),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_address (cpu_address),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .fill_start  (fill_start),
    .fill_base   (fill_base),
    .fill_count  (fill_count),
    .fill_value  (fill_value),
    .fill_busy   (fill_busy),
    .fill_done   (fill_done),
    .mem_address (mem_address),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous VRAM model with one-cycle read latency.
  always @(posedge clock) begin
    if (mem_we) vram[mem_address] <= mem_wdata;
    mem_rdata <= vram[mem_address];
  end

  typedef struct {
    logic          vid;
    logic [AW-1:0] vaddr;
    logic          creq;
    logic          cwe;
    logic [AW-1:0] caddr;
    logic [7:0]    cwd;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [7:0]    e_wd;
    logic          e_vv;
    logic [7:0]    e_vd;
    logic          e_ack;
    logic [7:0]    e_rd;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    vid_req = 1'b0; vid_address = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_address = '0; cpu_wdata = '0;
    fill_start = 1'b0; fill_base = '0; fill_count = '0; fill_value = '0;
  endtask

  task automatic start_fill(input logic [AW-1:0] base, input logic [FW-1:0] cnt, input logic [7:0] val);
    fill_base = base; fill_count = cnt; fill_value = val; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] exp43 [4];
    int writes;
    bit done_seen;
    bit any_we;
    bit any_done;
    bit any_busy;

    for (int i = 0; i < (1<<AW); i++) vram[i] = 8'h00;
    idle_inputs();

    // Reset with every requester active: no write may reach memory.
    reset = 1'b1;
    vid_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_address = 17'h00123; cpu_wdata = 8'hEE;
    fill_start = 1'b1; fill_base = 17'h00500; fill_count = 12'd3; fill_value = 8'h99;
    tick();
    tick();
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_vid_valid", 32'(vid_valid), 32'd0);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_fill_busy", 32'(fill_busy), 32'd0);
    check("rst_fill_done", 32'(fill_done), 32'd0);
    idle_inputs();
    reset = 1'b0;
    tick();
    check("post_rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("post_rst_fill_busy", 32'(fill_busy), 32'd0);

    //          vid   vaddr      creq  cwe   caddr      cwd    e_addr     e_we  e_wd   e_vv  e_vd   e_ack e_rd
    vecs[0]  = '{1'b0, 17'h00000, 1'b0, 1'b0, 17'h00000, 8'h00, 17'h00000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 17'h00000, 1'b1, 1'b1, 17'h1E000, 8'h41, 17'h1E000, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[2]  = '{1'b0, 17'h00000, 1'b1, 1'b1, 17'h1E000, 8'h41, 17'h00000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 17'h00000, 1'b0, 1'b0, 17'h00000, 8'h00, 17'h00000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 17'h00000, 1'b1, 1'b0, 17'h1E000, 8'h00, 17'h1E000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h41};
    vecs[5]  = '{1'b0, 17'h00000, 1'b0, 1'b0, 17'h00000, 8'h00, 17'h00000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 17'h1E000, 1'b1, 1'b1, 17'h00010, 8'h5A, 17'h1E000, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 8'h00};
    vecs[7]  = '{1'b1, 17'h1E000, 1'b1, 1'b1, 17'h00010, 8'h5A, 17'h1E000, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 17'h1E000, 1'b1, 1'b1, 17'h00010, 8'h5A, 17'h1E000, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 17'h00000, 1'b1, 1'b1, 17'h00010, 8'h5A, 17'h00010, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[10] = '{1'b0, 17'h00000, 1'b1, 1'b1, 17'h00010, 8'h5A, 17'h00000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[11] = '{1'b1, 17'h00010, 1'b0, 1'b0, 17'h00000, 8'h00, 17'h00010, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 8'h00};
    vecs[12] = '{1'b0, 17'h00000, 1'b0, 1'b0, 17'h00000, 8'h00, 17'h00000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};

    foreach (vecs[i]) begin
      vid_req = vecs[i].vid; vid_address = vecs[i].vaddr;
      cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe;
      cpu_address = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
      #1;
      check($sformatf("v%0d_mem_address", i), 32'(mem_address), 32'(vecs[i].e_addr));
      check($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      check($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_wd));
      tick();
      check($sformatf("v%0d_vid_valid", i), 32'(vid_valid), 32'(vecs[i].e_vv));
      check($sformatf("v%0d_cpu_ack", i), 32'(cpu_ack), 32'(vecs[i].e_ack));
      if (vecs[i].e_vv) check($sformatf("v%0d_vid_data", i), 32'(vid_data), 32'(vecs[i].e_vd));
      if (vecs[i].e_ack && !vecs[i].cwe) check($sformatf("v%0d_cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].e_rd));
    end

    // Reset while the CPU waits behind video: the parked access is dropped.
    vid_req = 1'b1; vid_address = 17'h1E000;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_address = 17'h00777; cpu_wdata = 8'h33;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    check("cpu_abort_mem_we", 32'(mem_we), 32'd0);
    check("cpu_abort_mem_address", 32'(mem_address), 32'd0);
    tick();
    check("cpu_abort_ack", 32'(cpu_ack), 32'd0);

`ifdef VRAM_FILL_EN
    // Wrapping fill; a second start mid-run must be ignored.
    exp43[0] = 17'h1FFFE; exp43[1] = 17'h1FFFF; exp43[2] = 17'h00000; exp43[3] = 17'h00001;
    start_fill(17'h1FFFE, 12'd4, 8'h20);
    for (int i = 0; i < 4; i++) begin
      fill_start = (i == 1); fill_base = 17'h05000; fill_count = 12'd9; fill_value = 8'hC3;
      #1;
      check($sformatf("f43_busy%0d", i), 32'(fill_busy), 32'd1);
      check($sformatf("f43_we%0d", i), 32'(mem_we), 32'd1);
      check($sformatf("f43_addr%0d", i), 32'(mem_address), 32'(exp43[i]));
      check($sformatf("f43_wdata%0d", i), 32'(mem_wdata), 32'h20);
      tick();
    end
    fill_start = 1'b0;
    check("f43_busy_end", 32'(fill_busy), 32'd0);
    check("f43_done", 32'(fill_done), 32'd1);
    tick();
    check("f43_done_pulse", 32'(fill_done), 32'd0);
    check("f43_no_restart", 32'(fill_busy), 32'd0);
    check("f43_vram0", 32'(vram[17'h00000]), 32'h20);
    check("f43_vram_top", 32'(vram[17'h1FFFF]), 32'h20);

    // Zero-length fill: no busy, done pulse on the next cycle.
    start_fill(17'h00300, 12'd0, 8'h11);
    check("f0_busy", 32'(fill_busy), 32'd0);
    check("f0_done", 32'(fill_done), 32'd1);
    tick();
    check("f0_done_pulse", 32'(fill_done), 32'd0);

    // CPU write into the fill range wins its cycle; the fill later overwrites it.
    start_fill(17'h00200, 12'd4, 8'hAA);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_address = 17'h00202; cpu_wdata = 8'h11;
    #1;
    check("f30_cpu_addr", 32'(mem_address), 32'h202);
    check("f30_cpu_wdata", 32'(mem_wdata), 32'h11);
    tick();
    check("f30_cpu_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("f30_addr%0d", i), 32'(mem_address), 32'(17'h00200 + i));
      check($sformatf("f30_we%0d", i), 32'(mem_we), 32'd1);
      tick();
    end
    check("f30_done", 32'(fill_done), 32'd1);
    check("f30_overwrite", 32'(vram[17'h00202]), 32'hAA);

    // Video every other cycle: fill only writes in the gaps.
    start_fill(17'h00100, 12'd8, 8'h77);
    writes = 0;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
      vid_req = ((cyc % 2) == 0); vid_address = 17'h1E000;
      #1;
      if (vid_req) begin
        check($sformatf("f44_vid_excl%0d", cyc), 32'(mem_we), 32'd0);
      end else if (mem_we) begin
        check($sformatf("f44_addr%0d", writes), 32'(mem_address), 32'(17'h00100 + writes));
        writes++;
      end
      tick();
      if (fill_done) begin
        done_seen = 1'b1;
        check("f44_writes_at_done", 32'(writes), 32'd8);
      end
    end
    vid_req = 1'b0;
    check("f44_done_seen", 32'(done_seen), 32'd1);
    check("f44_writes", 32'(writes), 32'd8);
    tick();
    check("f44_done_once", 32'(fill_done), 32'd0);
    check("f44_busy_end", 32'(fill_busy), 32'd0);

    // Reset after two of ten writes aborts silently; a later start works.
    start_fill(17'h00300, 12'd10, 8'h55);
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("f45_we%0d", i), 32'(mem_we), 32'd1);
      tick();
    end
    reset = 1'b1;
    #1;
    check("f45_rst_we", 32'(mem_we), 32'd0);
    tick();
    reset = 1'b0;
    check("f45_busy", 32'(fill_busy), 32'd0);
    any_we = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (mem_we) any_we = 1'b1;
      if (fill_done) any_done = 1'b1;
      tick();
    end
    check("f45_no_writes", 32'(any_we), 32'd0);
    check("f45_no_done", 32'(any_done), 32'd0);
    check("f45_vram_untouched", 32'(vram[17'h00302]), 32'h00);
    start_fill(17'h00400, 12'd1, 8'h66);
    check("f45_restart_busy", 32'(fill_busy), 32'd1);
    #1;
    check("f45_restart_addr", 32'(mem_address), 32'h400);
    check("f45_restart_we", 32'(mem_we), 32'd1);
    tick();
    check("f45_restart_done", 32'(fill_done), 32'd1);
`else
    // Fill engine absent: start pulses have no effect.
    start_fill(17'h00100, 12'd4, 8'h20);
    any_we = 1'b0;
    any_done = 1'b0;
    any_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (mem_we) any_we = 1'b1;
      if (fill_busy) any_busy = 1'b1;
      if (fill_done) any_done = 1'b1;
      tick();
    end
    check("nofill_we", 32'(any_we), 32'd0);
    check("nofill_busy", 32'(any_busy), 32'd0);
    check("nofill_done", 32'(any_done), 32'd0);
    check("nofill_vram", 32'(vram[17'h00100]), 32'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter: AW, default 17, VRAM byte address width.
REQ-002 Parameter: FW, default 12, fill length counter width.
REQ-003 clock  in  1  single system clock; all state changes on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 vid_req  in  1  video fetch request for this cycle (highest priority).
REQ-006 vid_address  in  AW  video fetch byte address.
REQ-007 vid_valid  out  1  high the cycle after a video grant; vid_data is valid then.
REQ-008 vid_data  out  8  read data to video; equals mem_rdata.
REQ-009 cpu_req  in  1  CPU access request; held high until cpu_ack.
REQ-010 cpu_we  in  1  CPU write (1) or read (0).
REQ-011 cpu_address  in  AW  CPU byte address.
REQ-012 cpu_wdata  in  8  CPU write data.
REQ-013 cpu_ack  out  1  one-cycle completion pulse.
REQ-014 cpu_rdata  out  8  read data, valid while cpu_ack is high on a read.
REQ-015 fill_start  in  1  one-cycle pulse that starts a block fill.
REQ-016 fill_base / fill_count / fill_value  in  AW / FW / 8  fill start address, byte count and byte value.
REQ-017 fill_busy  out  1  fill in progress.
REQ-018 fill_done  out  1  one-cycle pulse after the last fill write.
REQ-019 mem_address / mem_we / mem_wdata  out  AW / 1 / 8  single-port VRAM command; combinational from the current grant.
REQ-020 mem_rdata  in  8  VRAM read data, valid one cycle after the address is presented.

Function
REQ-021 Exactly one requester is granted per cycle, with fixed priority video > CPU > fill.
REQ-022 With no grant, mem_address = 0, mem_we = 0 and mem_wdata = 0.
REQ-023 Video grant: mem_address = vid_address and mem_we = 0; vid_valid = 1 next cycle. Latency is 1 and video is never stalled.
REQ-024 CPU FSM has states C_IDLE, C_WAIT and C_ACK.
- C_IDLE: on cpu_req, go to C_ACK if the CPU is granted this cycle, otherwise to C_WAIT.
- C_WAIT: go to C_ACK on the first cycle with no vid_req.
- C_ACK: cpu_ack = 1, then return to C_IDLE.
REQ-025 cpu_req is ignored in C_ACK, so a request held through the ack is not serviced twice; a new access needs cpu_req high in C_IDLE.
REQ-026 CPU read data: cpu_rdata = mem_rdata during C_ACK. CPU write: mem_we = 1 only in the granted cycle.
REQ-027 Fill FSM has states F_IDLE and F_RUN.
- F_IDLE: fill_start loads the address from fill_base and the remaining count from fill_count.
  - fill_count = 0: stay in F_IDLE and pulse fill_done next cycle.
  - fill_count > 0: go to F_RUN.
- F_RUN: fill_busy = 1; each cycle the fill is granted, write fill_value, increment the address and decrement the count.
  - When the count reaches 0, return to F_IDLE and pulse fill_done on the following cycle.
REQ-028 fill_start is ignored while in F_RUN.
REQ-029 Fill address increments modulo 2^AW (0x1FFFF wraps to 0x00000).
REQ-030 A CPU write to a fill-range address is not reordered: the CPU always wins that cycle, and a later fill write to the same address overwrites it.
REQ-031 If vid_req and cpu_req are high in the same cycle, video is granted and the CPU goes to C_WAIT, with no access lost.

Reset
REQ-032 Reset aborts any CPU or fill operation in progress and returns both FSMs to C_IDLE and F_IDLE.
REQ-033 On reset: vid_valid = 0, cpu_ack = 0, fill_busy = 0 and fill_done = 0.
REQ-034 While reset is high, mem_we = 0 regardless of the requests.
REQ-035 No fill_done pulse is generated for a fill aborted by reset.

Configuration
REQ-036 Macro VRAM_FILL_EN compiles in the fill engine as specified above.
REQ-037 Without VRAM_FILL_EN:
- fill_busy and fill_done are tied to 0.
- fill_start and the other fill inputs are ignored.
- No fill writes are ever issued.
- The port list is unchanged.

Structure
REQ-038 Shared package vram_pkg holds the AW/FW defaults, the CPU and fill state encodings, and the grant enum (G_NONE, G_VID, G_CPU, G_FILL).
REQ-039 The fill engine is sub-module vram_fill (fill FSM, address and counter), instantiated only under VRAM_FILL_EN.
REQ-040 Arbitration and the CPU FSM remain in vram_arbiter.

Verification
REQ-041 CPU write with video idle: cpu_we=1, cpu_address=0x1E000, cpu_wdata=0x41 -> the same cycle shows mem_we=1 and mem_address=0x1E000; cpu_ack pulses next cycle; a readback gives cpu_rdata=0x41.
REQ-042 Video contention: vid_req held for 3 cycles while cpu_req rises in the first of them -> CPU in C_WAIT for 3 cycles, granted in cycle 4, cpu_ack in cycle 5; vid_valid high in cycles 2-4.
REQ-043 Fill: base=0x1FFFE, count=4, value=0x20 -> writes to 0x1FFFE, 0x1FFFF, 0x00000 and 0x00001; fill_busy high for 4 cycles; one fill_done pulse.
REQ-044 Fill interleave: a fill of count 8 with vid_req asserted every other cycle -> exactly 8 writes, no write while video is granted, and fill_done after the 8th write.
REQ-045 Reset mid-fill: reset asserted after 2 of 10 writes -> no further writes, fill_busy=0, no fill_done; a subsequent fill_start is accepted.
REQ-046 Build without VRAM_FILL_EN: fill_start pulse -> mem_we never asserted by the fill, fill_busy=0 and fill_done=0.
